// File: rtl/rpll_supervisor_pkg.sv
// Shared types and widths for the rPLL supervisor.
package rpll_supervisor_pkg;

    localparam int SEL_W  = 6;
    localparam int RCNT_W = 8;

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rpll_supervisor_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rpll_supervisor.sv
// rPLL reset/lock supervisor with retry budget and select-code reconfiguration.
module rpll_supervisor
    import rpll_supervisor_pkg::*;
#(
    parameter int               RST_CYCLES   = 16,
    parameter int               LOCK_STABLE  = 1024,
    parameter int               LOCK_TIMEOUT = 65535,
    parameter int               MAX_RETRY    = 3,
    parameter logic [SEL_W-1:0] DEF_FBDSEL   = '0,
    parameter logic [SEL_W-1:0] DEF_IDSEL    = '0,
    parameter logic [SEL_W-1:0] DEF_ODSEL    = '0
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [SEL_W-1:0]  pll_fbdsel,
    output logic [SEL_W-1:0]  pll_idsel,
    output logic [SEL_W-1:0]  pll_odsel,
    input  logic [SEL_W-1:0]  cfg_fbdsel,
    input  logic [SEL_W-1:0]  cfg_idsel,
    input  logic [SEL_W-1:0]  cfg_odsel,
    input  logic              cfg_req,
    output logic              cfg_ready,
    output logic              cfg_done,
    output logic              clk_ok,
    output logic              fail,
    output logic [RCNT_W-1:0] relock_cnt
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTRY_W  = $clog2(MAX_RETRY + 1);

    // The lock sample that moves WAIT_LOCK to STABLE is the first of the run.
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST =
        CNT_W'((LOCK_STABLE > 1) ? LOCK_STABLE - 2 : 0);

    logic lock_s;

    sync2 u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RTRY_W-1:0]   retry_q, retry_d;
    logic                pending_q, pending_d;
    logic                pll_reset_q, pll_reset_d;
    logic [SEL_W-1:0]    fbdsel_q, fbdsel_d;
    logic [SEL_W-1:0]    idsel_q, idsel_d;
    logic [SEL_W-1:0]    odsel_q, odsel_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                cfg_done_q, cfg_done_d;
    logic                clk_ok_q, clk_ok_d;
    logic                fail_q, fail_d;
    logic [RCNT_W-1:0]   relock_q, relock_d;
    logic                xfer;

    assign xfer = cfg_req && cfg_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        retry_d    = retry_q;
        pending_d  = pending_q;
        fbdsel_d   = fbdsel_q;
        idsel_d    = idsel_q;
        odsel_d    = odsel_q;
        cfg_done_d = 1'b0;
        relock_d   = relock_q;
        unique case (state_q)
            ST_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    retry_d = retry_q + RTRY_W'(1);
                    cnt_d   = '0;
                    state_d = (retry_d == RTRY_W'(MAX_RETRY)) ? ST_FAIL
                                                               : ST_RST;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    retry_d    = '0;
                    cfg_done_d = pending_q;
                    pending_d  = 1'b0;
                end
            end
            ST_RUN, ST_FAIL: begin
                cnt_d = '0;
                // A transfer wins over a simultaneous lock loss.
                if (xfer) begin
                    state_d   = ST_RST;
                    fbdsel_d  = cfg_fbdsel;
                    idsel_d   = cfg_idsel;
                    odsel_d   = cfg_odsel;
                    retry_d   = '0;
                    pending_d = 1'b1;
                end else if (state_q == ST_RUN && !lock_s) begin
                    state_d = ST_RST;
                    if (relock_q != '1)
                        relock_d = relock_q + RCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase
        pll_reset_d = (state_d == ST_RST);
        clk_ok_d    = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
        cfg_ready_d = (state_d == ST_RUN) || (state_d == ST_FAIL);
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pending_q   <= 1'b0;
            pll_reset_q <= 1'b1;
            fbdsel_q    <= DEF_FBDSEL;
            idsel_q     <= DEF_IDSEL;
            odsel_q     <= DEF_ODSEL;
            cfg_ready_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            clk_ok_q    <= 1'b0;
            fail_q      <= 1'b0;
            relock_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pending_q   <= pending_d;
            pll_reset_q <= pll_reset_d;
            fbdsel_q    <= fbdsel_d;
            idsel_q     <= idsel_d;
            odsel_q     <= odsel_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_done_q  <= cfg_done_d;
            clk_ok_q    <= clk_ok_d;
            fail_q      <= fail_d;
            relock_q    <= relock_d;
        end
    end

    assign pll_reset  = pll_reset_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_idsel  = idsel_q;
    assign pll_odsel  = odsel_q;
    assign cfg_ready  = cfg_ready_q;
    assign cfg_done   = cfg_done_q;
    assign clk_ok     = clk_ok_q;
    assign fail       = fail_q;
    assign relock_cnt = relock_q;

endmodule

// File: doc/rpll_supervisor.md
RPLL_SUPERVISOR -- requirements
Module: rpll_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of clkin cycles the PLL reset is held asserted.
REQ-002 SHALL have parameter LOCK_STABLE, default 1024: number of consecutive synchronized-lock cycles required before clk_ok.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: number of cycles spent waiting for lock before a retry.
REQ-004 SHALL have parameter MAX_RETRY, default 3: number of consecutive timeouts before FAIL.
REQ-005 SHALL have parameters DEF_FBDSEL, DEF_IDSEL and DEF_ODSEL, each 6 bits, default 0: the reset values of the dynamic select codes.
REQ-006 SHALL have port clkin, input, 1 bit: free-running reference clock; the sole clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port pll_lock, input, 1 bit: PLL LOCK, asynchronous to clkin.
REQ-009 SHALL have port pll_reset, output, 1 bit: drives the PLL RESET.
REQ-010 SHALL have ports pll_fbdsel, pll_idsel and pll_odsel, each output, 6 bits: drive the PLL FBDSEL, IDSEL and ODSEL.
REQ-011 SHALL have ports cfg_fbdsel, cfg_idsel and cfg_odsel, each input, 6 bits: requested select codes.
REQ-012 SHALL have ports cfg_req (input, 1 bit) and cfg_ready (output, 1 bit): valid/ready reconfiguration handshake.
REQ-013 SHALL have port cfg_done, output, 1 bit: one-cycle pulse when a reconfiguration reaches RUN.
REQ-014 SHALL have port clk_ok, output, 1 bit: PLL output is locked and stable.
REQ-015 SHALL have port fail, output, 1 bit: retry budget exhausted.
REQ-016 SHALL have port relock_cnt, output, 8 bits: saturating count of lock losses in RUN.

Function
REQ-017 SHALL pass pll_lock through a 2-flop synchronizer to produce lock_s; all decisions use lock_s only.
REQ-018 SHALL implement FSM states RST, WAIT_LOCK, STABLE, RUN and FAIL, with a single shared cycle counter that is cleared on every state change.
REQ-019 RST: pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-020 WAIT_LOCK: pll_reset=0; lock_s=1 -> STABLE; counter reaching LOCK_TIMEOUT -> retry+1, then FAIL if retry equals MAX_RETRY, otherwise RST.
REQ-021 STABLE: LOCK_STABLE consecutive lock_s=1 cycles -> RUN with retry cleared; any lock_s=0 -> WAIT_LOCK with the timeout counter restarted.
REQ-022 RUN: clk_ok=1 is registered and asserts on the first RUN cycle; lock_s=0 -> RST, clk_ok=0 from the next cycle, relock_cnt+1 saturating at 255.
REQ-023 FAIL: fail=1 and pll_reset=0; remain in FAIL until a cfg transfer or rst_n.
REQ-024 cfg_ready=1 only in RUN or FAIL; a transfer occurs when cfg_req and cfg_ready are both high in the same cycle.
REQ-025 On a transfer, latch the cfg_* codes onto the pll_* select outputs the next cycle, clear retry and fail, set the pending flag, and go to RST.
REQ-026 A lock loss coinciding with a transfer in RUN SHALL be treated as the transfer only, with relock_cnt not incremented.
REQ-027 cfg_done SHALL pulse high for one cycle on entry to RUN when the pending flag is set; the pending flag then clears.
REQ-028 cfg_req while cfg_ready=0 SHALL be ignored, with no latching.
REQ-029 The select outputs SHALL change only on a transfer and SHALL remain stable across retries.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state=RST, counter=0, retry=0, pll_reset=1, pll_*sel=DEF_*, clk_ok=0, fail=0, cfg_ready=0, cfg_done=0, relock_cnt=0, pending=0, synchronizer=0.
REQ-031 Reset deassertion SHALL be synchronized to clkin, and RST timing starts on the first clkin edge after release.
REQ-032 Reset asserted mid-operation (any state, including mid-reconfiguration) SHALL discard latched cfg codes and return the selects to DEF_*.

Structure
REQ-033 Shared package rpll_supervisor_pkg SHALL hold the state encoding, the select-code width (6) and the relock_cnt width (8).
REQ-034 The sub-module sync2 (2-flop synchronizer, async active-low reset) SHALL be used for pll_lock.
REQ-035 The counter width SHALL be sized from the maximum of RST_CYCLES, LOCK_STABLE and LOCK_TIMEOUT.

Verification
Benches SHALL use RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32 and MAX_RETRY=2.
REQ-036 Scenario: release rst_n, raise pll_lock 10 cycles later -> pll_reset high for 4 cycles; clk_ok rises 8 cycles after lock_s; fail=0.
REQ-037 Scenario: pll_lock held 0 -> two 4-cycle reset pulses, each followed by 32 cycles of waiting, then fail=1, cfg_ready=1, pll_reset=0.
REQ-038 Scenario: in RUN, drop pll_lock for 1 cycle -> clk_ok falls, relock_cnt=1, new 4-cycle reset pulse; clk_ok returns after re-lock+8.
REQ-039 Scenario: in RUN, cfg_req with codes 0x09/0x00/0x08 -> pll_*sel updated, reset pulse issued, cfg_done pulses once on re-lock, clk_ok=1.
REQ-040 Scenario: in FAIL, cfg transfer with pll_lock=1 -> fail clears and RUN is reached with cfg_done; a separate case with rst_n asserted in STABLE -> all outputs return to reset values.
REQ-041 Scenario: transfer coincident with lock loss -> relock_cnt unchanged and the reconfiguration proceeds.
